// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Write-side front end of the integer register file. Results from the ALU and
// the LSU arrive over valid/ready handshakes, pass through a small in-order
// FIFO, and are drained one per cycle onto the register file's single write
// port. Results that target register 0 are accepted and dropped. A
// pending-register mask tells the issue stage which registers still have a
// buffered write outstanding.
//
// Optional feature (macro RF_WB_BYPASS_EN): when the FIFO is empty and the
// drain is not stalled, an accepted result goes straight to the write port in
// the same cycle instead of being enqueued. Without the macro every result
// passes through the FIFO. Ready logic is the same in both builds.
//
// Parameters:
//   DATA_WIDTH   register data width
//   REG_NUM_BIT  register address width (mask is 2**REG_NUM_BIT bits)
//   DEPTH        FIFO entries, power of two, >= 2
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data   LSU result handshake (higher priority)
//   wb_stall                      holds the drain, no write while high
//   wen/waddr/wdata               register file write port
//   pending_mask                  bit i set if a buffered entry targets reg i
//   count                         FIFO occupancy

module rf_write_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM_BIT = 5,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [REG_NUM_BIT-1:0]     alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [REG_NUM_BIT-1:0]     lsu_rd,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  input  logic                       wb_stall,
  output logic                       wen,
  output logic [REG_NUM_BIT-1:0]     waddr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic [2**REG_NUM_BIT-1:0]  pending_mask,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_NUM_BIT-1:0] ent_rd   [DEPTH];
  logic [DATA_WIDTH-1:0]  ent_data [DEPTH];
  logic [DEPTH-1:0]       ent_valid;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          cnt;

  logic                   not_full;
  logic                   lsu_fire;
  logic                   alu_fire;
  logic [REG_NUM_BIT-1:0] acc_rd;
  logic [DATA_WIDTH-1:0]  acc_data;
  logic                   acc_en;
  logic                   pop;
  logic                   push;
  logic                   bypass;

  // Readiness looks only at occupancy and lsu_valid, so no valid input can
  // combinationally reach its own ready. A pop in the full cycle does not
  // reopen the FIFO until the next cycle.
  assign not_full  = (cnt < CW'(DEPTH));
  assign lsu_ready = not_full;
  assign alu_ready = not_full && !lsu_valid;

  // alu_ready already excludes lsu_valid, so at most one side fires.
  assign lsu_fire = lsu_valid && lsu_ready;
  assign alu_fire = alu_valid && alu_ready;
  assign acc_rd   = lsu_fire ? lsu_rd   : alu_rd;
  assign acc_data = lsu_fire ? lsu_data : alu_data;

  // Results for register 0 complete the handshake but go nowhere.
  assign acc_en = (lsu_fire || alu_fire) && (acc_rd != '0);

  assign pop = (cnt != '0) && !wb_stall;

`ifdef RF_WB_BYPASS_EN
  // Empty queue and open drain: write the new result this cycle.
  assign bypass = acc_en && (cnt == '0) && !wb_stall;
`else
  assign bypass = 1'b0;
`endif

  assign push = acc_en && !bypass;

  // Write port: FIFO head has priority; bypass can only occur when empty.
  assign wen   = pop || bypass;
  assign waddr = pop ? ent_rd[rd_ptr]   : (bypass ? acc_rd   : '0);
  assign wdata = pop ? ent_data[rd_ptr] : (bypass ? acc_data : '0);
  assign count = cnt;

  // Pointer, occupancy and entry-valid bookkeeping. Reset discards every
  // buffered entry. Push and pop never address the same slot in one cycle:
  // a pop needs a non-empty queue and a push needs a non-full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload storage; contents are qualified by ent_valid so it needs
  // no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[wr_ptr]   <= acc_rd;
      ent_data[wr_ptr] <= acc_data;
    end
  end

  // Pending mask rebuilt from the live entries every cycle.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pending_mask[ent_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule
